// File: rtl/stim_replay_misr.sv
// Table-driven stimulus replayer with MISR response compaction.
// Plays a loaded table of vectors into a DUT, each vector held for a programmable
// number of cycles and optionally followed by zero-gap cycles. Every active cycle
// folds the DUT response into a signature that is compared against a golden value.
module stim_replay_misr #(
    parameter int unsigned IN_W   = 256,
    parameter int unsigned OUT_W  = 350,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned HOLD_W = 4,
    parameter logic [OUT_W-1:0] POLY = {{(OUT_W-8){1'b0}}, 8'h1D},
    parameter logic [OUT_W-1:0] SEED = {{(OUT_W-1){1'b0}}, 1'b1}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [IN_W-1:0]   wr_vec,
    input  logic [HOLD_W-1:0] wr_hold,
    input  logic [HOLD_W-1:0] wr_gap,
    input  logic [AW:0]       num_entries,
    input  logic              start,
    input  logic              abort,
    input  logic [OUT_W-1:0]  golden,
    input  logic [OUT_W-1:0]  resp,
    output logic [IN_W-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  sig,
    output logic              sig_match,
    output logic [15:0]       cap_count
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     idx, idx_nxt, idx_inc;
    logic [HOLD_W-1:0] cnt, cnt_nxt;
    logic [AW:0]       n_q, n_nxt, n_clamp;
    logic [IN_W-1:0]   stim_nxt;
    logic [OUT_W-1:0]  sig_nxt, sig_cap;
    logic [CNT_W-1:0]  cap_nxt, cap_inc;
    logic              busy_nxt, done_nxt, match_nxt;
    logic              last_entry, can_cfg;

    logic [IN_W-1:0]   tbl_vec  [DEPTH];
    logic [HOLD_W-1:0] tbl_hold [DEPTH];
    logic [HOLD_W-1:0] tbl_gap  [DEPTH];

    // A hold of zero behaves as a hold of one; the counter counts down to zero.
    function automatic logic [HOLD_W-1:0] hold_load(input logic [HOLD_W-1:0] h);
        return (h == '0) ? '0 : h - HOLD_W'(1);
    endfunction

    assign can_cfg    = (state == IDLE) || (state == DONE);
    assign idx_inc    = idx + AW'(1);
    assign last_entry = ((AW+1)'(idx) + (AW+1)'(1)) >= n_q;
    // Entry counts beyond the table are clamped so playback never reads past it.
    assign n_clamp    = (32'(num_entries) > DEPTH) ? (AW+1)'(DEPTH) : num_entries;
    assign sig_cap    = {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? POLY : '0) ^ resp;
    assign cap_inc    = (cap_count == '1) ? cap_count : cap_count + CNT_W'(1);

    // Table write port; dropped while playback runs or when out of range.
    always_ff @(posedge clk) begin
        if (wr_en && can_cfg && (32'(wr_addr) < DEPTH)) begin
            tbl_vec[wr_addr]  <= wr_vec;
            tbl_hold[wr_addr] <= wr_hold;
            tbl_gap[wr_addr]  <= wr_gap;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            n_q       <= '0;
            stim      <= '0;
            sig       <= SEED;
            cap_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sig_match <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            n_q       <= n_nxt;
            stim      <= stim_nxt;
            sig       <= sig_nxt;
            cap_count <= cap_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            sig_match <= match_nxt;
        end
    end

    // Next-state, sequencing counters and next output values.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        n_nxt     = n_q;
        sig_nxt   = sig;
        cap_nxt   = cap_count;
        match_nxt = sig_match;

        case (state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    sig_nxt = SEED;
                    cap_nxt = '0;
                    idx_nxt = '0;
                    if (num_entries == '0) begin
                        state_nxt = DONE;
                        match_nxt = (SEED == golden);
                    end else begin
                        state_nxt = PLAY;
                        n_nxt     = n_clamp;
                        cnt_nxt   = hold_load(tbl_hold[0]);
                        match_nxt = 1'b0;
                    end
                end
            end
            PLAY: begin
                sig_nxt   = sig_cap;
                cap_nxt   = cap_inc;
                match_nxt = 1'b0;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - HOLD_W'(1);
                end else if (tbl_gap[idx] != '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = tbl_gap[idx] - HOLD_W'(1);
                end else if (last_entry) begin
                    state_nxt = DONE;
                    match_nxt = (sig_cap == golden);
                end else begin
                    idx_nxt = idx_inc;
                    cnt_nxt = hold_load(tbl_hold[idx_inc]);
                end
            end
            GAP: begin
                sig_nxt   = sig_cap;
                cap_nxt   = cap_inc;
                match_nxt = 1'b0;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - HOLD_W'(1);
                end else if (last_entry) begin
                    state_nxt = DONE;
                    match_nxt = (sig_cap == golden);
                end else begin
                    state_nxt = PLAY;
                    idx_nxt   = idx_inc;
                    cnt_nxt   = hold_load(tbl_hold[idx_inc]);
                end
            end
            default: state_nxt = IDLE;
        endcase

        stim_nxt = (state_nxt == PLAY) ? tbl_vec[idx_nxt] : '0;
        busy_nxt = (state_nxt == PLAY) || (state_nxt == GAP);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_stim_replay_misr.sv
// Self-checking bench for stim_replay_misr in a small 8-bit configuration.
// The reference expands the table into a flat expected stimulus list and folds
// the driven responses into a signature with plain arithmetic.
module tb_stim_replay_misr;

    localparam int unsigned IN_W   = 8;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned DEPTH  = 6;
    localparam int unsigned AW     = 3;
    localparam int unsigned HOLD_W = 4;
    localparam logic [7:0]  POLY   = 8'h1D;
    localparam logic [7:0]  SEED   = 8'h01;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [IN_W-1:0]   wr_vec = '0;
    logic [HOLD_W-1:0] wr_hold = '0;
    logic [HOLD_W-1:0] wr_gap = '0;
    logic [AW:0]       num_entries = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [OUT_W-1:0]  golden = '0;
    logic [OUT_W-1:0]  resp = '0;
    logic [IN_W-1:0]   stim;
    logic              busy;
    logic              done;
    logic [OUT_W-1:0]  sig;
    logic              sig_match;
    logic [15:0]       cap_count;

    stim_replay_misr #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AW(AW), .HOLD_W(HOLD_W),
        .POLY(POLY), .SEED(SEED)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_vec(wr_vec), .wr_hold(wr_hold), .wr_gap(wr_gap),
        .num_entries(num_entries), .start(start), .abort(abort),
        .golden(golden), .resp(resp), .stim(stim), .busy(busy), .done(done),
        .sig(sig), .sig_match(sig_match), .cap_count(cap_count)
    );

    always #5 clk = ~clk;

    // Reference copy of the table contents the DUT is expected to hold.
    logic [7:0] m_vec  [DEPTH];
    int         m_hold [DEPTH];
    int         m_gap  [DEPTH];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Signature update: shift left by one, reduce by the polynomial on overflow, add response.
    function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] r);
        int v;
        v = int'(s) * 2;
        if (v >= 256) v = (v - 256) ^ int'(POLY);
        return 8'(v) ^ r;
    endfunction

    // Idle-time table write; the reference keeps only in-range entries.
    task automatic wr(input int a, input logic [7:0] v, input int h, input int g);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_vec  = v;
        wr_hold = HOLD_W'(h);
        wr_gap  = HOLD_W'(g);
        @(negedge clk);
        wr_en = 1'b0;
        if (a < int'(DEPTH)) begin
            m_vec[a]  = v;
            m_hold[a] = h;
            m_gap[a]  = g;
        end
    endtask

    // Run one playback and check it cycle by cycle against the expanded table.
    // resp_mode: 0 zero, 1 random, 2 zero except 8'hFF on the final capture.
    task automatic play(input int n, input int resp_mode, input bit bad_gold,
                        input int abort_at, input bit busy_wr);
        logic [7:0] qs[$];
        logic [7:0] qr[$];
        logic [7:0] s;
        logic [7:0] gold;
        int         len;
        int         caps;
        bit         ab;
        for (int e = 0; e < n; e++) begin
            int h;
            h = (m_hold[e] == 0) ? 1 : m_hold[e];
            for (int k = 0; k < h; k++) qs.push_back(m_vec[e]);
            for (int k = 0; k < m_gap[e]; k++) qs.push_back(8'h00);
        end
        len = qs.size();
        for (int i = 0; i < len; i++) begin
            case (resp_mode)
                0:       qr.push_back(8'h00);
                1:       qr.push_back(8'($urandom));
                default: qr.push_back((i == len - 1) ? 8'hFF : 8'h00);
            endcase
        end
        ab   = (abort_at >= 0) && (abort_at < len);
        caps = ab ? abort_at + 1 : len;
        s = SEED;
        for (int i = 0; i < caps; i++) s = misr(s, qr[i]);
        gold = bad_gold ? (s ^ 8'h01) : s;

        golden      = gold;
        num_entries = (AW+1)'(n);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = SEED;
        for (int i = 0; i < caps; i++) begin
            check("stim", 32'(stim), 32'(qs[i]));
            check("busy", 32'(busy), 32'd1);
            check("sig_run", 32'(sig), 32'(s));
            check("cap_run", 32'(cap_count), 32'(i));
            resp = qr[i];
            s = misr(s, qr[i]);
            if (i == abort_at) abort = 1'b1;
            if (busy_wr && i == 0) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_vec  = ~m_vec[0];
                wr_hold = HOLD_W'(m_hold[0] + 1);
                wr_gap  = HOLD_W'(m_gap[0] + 1);
            end
            @(negedge clk);
            abort = 1'b0;
            wr_en = 1'b0;
            resp  = 8'h00;
        end
        check("stim_end", 32'(stim), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("done_end", 32'(done), 32'(!ab));
        check("sig_end", 32'(sig), 32'(s));
        check("cap_end", 32'(cap_count), 32'(caps));
        check("match_end", 32'(sig_match), 32'(!ab && !bad_gold));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_stim", 32'(stim), 32'd0);
        check("rst_sig", 32'(sig), 32'(SEED));
        check("rst_cap", 32'(cap_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_match", 32'(sig_match), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single entry, hold 3: sig 01->02->04->08
        wr(0, 8'hA5, 3, 0);
        play(1, 0, 1'b0, -1, 1'b0);
        check("t1_sig", 32'(sig), 32'h08);
        check("t1_cap", 32'(cap_count), 32'd3);

        // Hold then gap then next entry with no bubble
        wr(0, 8'hA5, 2, 1);
        wr(1, 8'h3C, 1, 0);
        play(2, 0, 1'b0, -1, 1'b0);
        check("t2_sig", 32'(sig), 32'h10);
        check("t2_cap", 32'(cap_count), 32'd4);

        // Signature reaches 80 after 7 zero captures; FF on the 8th gives E2
        wr(0, 8'h5A, 8, 0);
        play(1, 2, 1'b0, -1, 1'b0);
        check("t3_sig", 32'(sig), 32'hE2);
        check("t3_match", 32'(sig_match), 32'd1);
        play(1, 2, 1'b1, -1, 1'b0);
        check("t3_golden_e3", 32'(golden), 32'hE3);
        check("t3_nomatch", 32'(sig_match), 32'd0);

        // Abort in the 2nd cycle of a hold-5 entry, then restart
        wr(0, 8'hA5, 5, 0);
        play(1, 0, 1'b0, 1, 1'b0);
        check("t4_cap", 32'(cap_count), 32'd2);
        check("t4_sig", 32'(sig), 32'h04);
        play(1, 0, 1'b0, -1, 1'b0);

        // Zero entries
        play(0, 0, 1'b0, -1, 1'b0);
        check("t5_sig", 32'(sig), 32'h01);
        check("t5_cap", 32'(cap_count), 32'd0);

        // Hold 0 gives one capture; write while busy is dropped
        wr(0, 8'hC3, 0, 0);
        wr(1, 8'h99, 1, 2);
        play(2, 1, 1'b0, -1, 1'b1);
        play(2, 0, 1'b0, -1, 1'b0);
        check("t6_cap", 32'(cap_count), 32'd4);

        // Out-of-range writes are dropped
        wr(6, 8'hEE, 3, 3);
        wr(7, 8'hDD, 2, 2);
        play(2, 1, 1'b0, -1, 1'b0);

        // Asynchronous reset in the middle of a gap
        wr(0, 8'hA5, 2, 1);
        wr(1, 8'h3C, 1, 0);
        golden      = 8'h00;
        num_entries = (AW+1)'(2);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t7_play", 32'(stim), 32'hA5);
        @(negedge clk);
        @(negedge clk);
        check("t7_gap_busy", 32'(busy), 32'd1);
        check("t7_gap_stim", 32'(stim), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_sig", 32'(sig), 32'(SEED));
        check("t7_rst_cap", 32'(cap_count), 32'd0);
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_done", 32'(done), 32'd0);
        check("t7_rst_match", 32'(sig_match), 32'd0);
        check("t7_rst_stim", 32'(stim), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        play(2, 1, 1'b0, -1, 1'b0);

        // Randomized tables, responses, goldens, aborts and busy writes
        for (int it = 0; it < 30; it++) begin
            int n;
            int ab_at;
            for (int a = 0; a < int'(DEPTH); a++)
                wr(a, 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            n     = int'($urandom_range(0, DEPTH));
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
            play(n, 1, 1'($urandom_range(0, 1)), ab_at, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stim_replay_misr.md
Name: stim_replay_misr

Overview:
- Synthesizable, parametrised successor to the fuzz identity-testbench stimulus/strobe loop.
- Replays a loaded table of wide input vectors into a DUT, each held for a programmable number of cycles and optionally followed by zero-gap cycles.
- Compacts the DUT response every active cycle into a MISR signature and compares it against a golden value.
- Sits between the DUT (`top`) and the on-chip fuzz harness, so gate-level and RTL runs can be compared by signature instead of text strobes.

Parameters:
- IN_W, 256, width of the stimulus vector driven to the DUT.
- OUT_W, 350, width of the DUT response `y`.
- DEPTH, 32, number of table entries.
- AW, 5, table address width; DEPTH must be ≤ 2**AW.
- HOLD_W, 4, width of the per-entry hold and gap counts.
- POLY, {{(OUT_W-8){1'b0}},8'h1D}, MISR feedback polynomial.
- SEED, {{(OUT_W-1){1'b0}},1'b1}, MISR value after reset and at each start.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  table write strobe; honoured only in IDLE or DONE.
- wr_addr  in  AW  table write address.
- wr_vec  in  IN_W  stimulus vector to write.
- wr_hold  in  HOLD_W  cycles to present the vector; 0 is treated as 1.
- wr_gap  in  HOLD_W  zero cycles inserted after the vector.
- num_entries  in  AW+1  entries to play; sampled at start.
- start  in  1  begin playback; honoured only in IDLE or DONE.
- abort  in  1  stop playback.
- golden  in  OUT_W  expected final signature.
- resp  in  OUT_W  DUT response.
- stim  out  IN_W  vector driven to the DUT.
- busy  out  1  high in PLAY or GAP.
- done  out  1  high in DONE.
- sig  out  OUT_W  current MISR value.
- sig_match  out  1  in DONE, sig == golden; otherwise 0.
- cap_count  out  16  responses captured since start (saturating).

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; stim = 0; sig = SEED; cap_count = 0; busy = done = sig_match = 0.
  - Table contents are not reset.
- Table write: synchronous, one entry per cycle. Writes with wr_addr ≥ DEPTH are dropped. Writes while busy are dropped.
- States:
  - IDLE: waits for start.
  - PLAY: presents the current entry's vector.
  - GAP: presents zeros between entries.
  - DONE: playback finished; sig is stable.
- IDLE/DONE + start:
  - If num_entries == 0: go to DONE (re-enter DONE if already there), with sig = SEED and cap_count = 0.
  - Otherwise: go to PLAY with idx = 0, hold counter loaded, sig = SEED, cap_count = 0.
- All outputs are registered. stim equals table[idx].vec in every cycle the state is PLAY, and equals 0 in every other state.
- Capture: on each rising edge where the state is PLAY or GAP, sample resp, then:
  - sig <= {sig[OUT_W-2:0],1'b0} ^ (sig[OUT_W-1] ? POLY : 0) ^ resp.
  - cap_count increments, saturating at 16'hFFFF.
- Capture count per entry: exactly max(hold,1) + gap captures.
- PLAY, hold counter expires:
  - gap ≠ 0 → GAP.
  - gap == 0 and more entries remain → PLAY with the next idx; stim changes on that same edge with no bubble.
  - gap == 0 and last entry → DONE.
- GAP, gap counter expires: next entry → PLAY, or → DONE after the last entry.
- DONE:
  - done = 1; sig and cap_count hold.
  - sig_match is registered on entry to DONE and is valid from the first DONE cycle.
- Priority abort > start. Abort in PLAY or GAP:
  - Go to IDLE next edge with stim = 0.
  - sig and cap_count hold their partial values; sig_match = 0.
  - Abort in IDLE or DONE is a no-op.
- Start while busy is ignored.
- Reset mid-playback returns every output to its reset value immediately.

Test Plan:
Small configuration for the bench: IN_W=8, OUT_W=8, POLY=8'h1D, SEED=8'h01, resp tied to 0 unless stated.
- Single entry (A5, hold 3, gap 0), start → stim = A5 for 3 cycles then 00; sig 01→02→04→08; cap_count = 3; done = 1.
- Entries (A5, hold 2, gap 1), (3C, hold 1, gap 0) → stim sequence A5, A5, 00, 3C, then 00; cap_count = 4; sig = 10.
- SEED=8'h80, resp = 8'hFF for 1 capture → sig = 1D ^ FF = E2; with golden = E2, sig_match = 1; with golden = E3, sig_match = 0.
- Abort in the 2nd cycle of a hold-5 entry → next cycle state IDLE, stim = 00, cap_count = 2, done = 0. A following start restarts with sig = SEED.
- num_entries = 0 with start → DONE next cycle, cap_count = 0, sig = 01. Also: hold = 0 entry yields 1 capture; a wr_en issued while busy leaves the table unchanged (verify by replay).
- rst_n asserted low mid-GAP (asynchronous, between edges) → all outputs return to reset values before the next edge; a wr_en to address ≥ DEPTH has no effect.
